// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: three requesters share one write port through
// a round-robin grant, with a one-cycle registered write and a busy scoreboard.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [2:0]             req_valid,
    input  logic [3*ADDR_W-1:0]    req_addr,
    input  logic [3*DATA_W-1:0]    req_data,
    output logic [2:0]             req_ready,
    input  logic                   rsv_valid,
    input  logic [ADDR_W-1:0]      rsv_addr,
    output logic                   RegWrite,
    output logic [ADDR_W-1:0]      A3,
    output logic [DATA_W-1:0]      WD3,
    output logic [2**ADDR_W-1:0]   busy
);

    localparam int NREG = 2**ADDR_W;

    logic [1:0]        ptr_q, ptr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic [1:0]        ptr_eff;
    logic [1:0]        order [3];
    logic [1:0]        grant_idx;
    logic              hs;
    logic              commit;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    function automatic logic [1:0] inc_mod3(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Grant depends only on valid, stall, pointer and reset -- never on addr/data.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        ptr_eff   = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
        order[0]  = ptr_eff;
        order[1]  = inc_mod3(ptr_eff);
        order[2]  = inc_mod3(order[1]);
        grant_idx = 2'd0;
        hs        = 1'b0;
        if (rst && !stall) begin
            // Scanning from the far end leaves the nearest valid requester as the winner.
            for (int k = 2; k >= 0; k--) begin
                if (req_valid[order[k]]) begin
                    grant_idx = order[k];
                    hs        = 1'b1;
                end
            end
        end
        req_ready = hs ? (3'b001 << grant_idx) : 3'b000;
    end

    always_comb begin
        case (grant_idx)
            2'd1: begin
                sel_addr = req_addr[ADDR_W +: ADDR_W];
                sel_data = req_data[DATA_W +: DATA_W];
            end
            2'd2: begin
                sel_addr = req_addr[2*ADDR_W +: ADDR_W];
                sel_data = req_data[2*DATA_W +: DATA_W];
            end
            default: begin
                sel_addr = req_addr[0 +: ADDR_W];
                sel_data = req_data[0 +: DATA_W];
            end
        endcase
    end

    always_comb begin
        commit     = hs && (sel_addr != '0);
        ptr_d      = hs ? inc_mod3(grant_idx) : ptr_eff;
        regwrite_d = commit;
        a3_d       = commit ? sel_addr : a3_q;
        wd3_d      = commit ? sel_data : wd3_q;

        // Reserve is applied after the clear so a same-address collision stays busy.
        busy_d = busy_q;
        if (commit) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the scoreboard is a plain flop vector, so it is cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= 2'd0;
            regwrite_q <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            a3_q       <= a3_d;
            wd3_q      <= wd3_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign A3       = a3_q;
    assign WD3      = wd3_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change on the falling edge,
// combinational grants are checked 1 ns later, registered outputs after each rising edge.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                 clk;
    logic                 rst;
    logic                 stall;
    logic [2:0]           req_valid;
    logic [3*ADDR_W-1:0]  req_addr;
    logic [3*DATA_W-1:0]  req_data;
    logic [2:0]           req_ready;
    logic                 rsv_valid;
    logic [ADDR_W-1:0]    rsv_addr;
    logic                 RegWrite;
    logic [ADDR_W-1:0]    A3;
    logic [DATA_W-1:0]    WD3;
    logic [2**ADDR_W-1:0] busy;

    int checks;
    int failures;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .RegWrite  (RegWrite),
        .A3        (A3),
        .WD3       (WD3),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                           input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d0,
                           input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        req_addr = {a2, a1, a0};
        req_data = {d2, d1, d0};
    endtask

    localparam logic [DATA_W-1:0] D0 = 32'hA000_0001;
    localparam logic [DATA_W-1:0] D1 = 32'hB000_0002;
    localparam logic [DATA_W-1:0] D2 = 32'hC000_0003;

    logic [DATA_W-1:0] dtab [3];
    logic [63:0] busy_exp;

    initial begin
        checks    = 0;
        failures  = 0;
        dtab[0]   = D0;
        dtab[1]   = D1;
        dtab[2]   = D2;
        rst       = 1'b1;
        stall     = 1'b0;
        req_valid = 3'b111;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        set_req(5'd1, 5'd2, 5'd3, D0, D1, D2);

        // Reset state, with all requesters valid to show grants are blocked.
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_a3", 64'(A3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst = 1'b1;

        // Round robin with all three valid: 0,1,2,0,1,2.
        for (int k = 0; k < 6; k++) begin
            #1 chk($sformatf("rr_ready_%0d", k), 64'(req_ready), 64'(3'b001 << (k % 3)));
            @(negedge clk);
            chk($sformatf("rr_we_%0d", k), 64'(RegWrite), 64'd1);
            chk($sformatf("rr_a3_%0d", k), 64'(A3), 64'((k % 3) + 1));
            chk($sformatf("rr_wd3_%0d", k), 64'(WD3), 64'(dtab[k % 3]));
        end
        req_valid = 3'b000;
        #1 chk("idle_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("idle_we", 64'(RegWrite), 64'd0);
        chk("idle_a3_hold", 64'(A3), 64'd3);
        chk("idle_wd3_hold", 64'(WD3), 64'(D2));

        // Lone requester 2.
        set_req(5'd1, 5'd2, 5'd7, D0, D1, 32'hDEADBEEF);
        req_valid = 3'b100;
        #1 chk("r2_ready", 64'(req_ready), 64'b100);
        @(negedge clk);
        chk("r2_we", 64'(RegWrite), 64'd1);
        chk("r2_a3", 64'(A3), 64'd7);
        chk("r2_wd3", 64'(WD3), 64'hDEADBEEF);
        req_valid = 3'b000;

        // Reserve register 5, later committed by requester 1.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        @(negedge clk);
        rsv_valid = 1'b0;
        chk("rsv_busy_set", 64'(busy), 64'h20);
        chk("rsv_no_we", 64'(RegWrite), 64'd0);
        @(negedge clk);
        chk("rsv_busy_hold", 64'(busy), 64'h20);
        set_req(5'd1, 5'd5, 5'd3, D0, 32'h0000_0055, D2);
        req_valid = 3'b010;
        #1 chk("cm5_ready", 64'(req_ready), 64'b010);
        @(negedge clk);
        chk("cm5_busy_clr", 64'(busy), 64'h0);
        chk("cm5_we", 64'(RegWrite), 64'd1);
        chk("cm5_a3", 64'(A3), 64'd5);
        chk("cm5_wd3", 64'(WD3), 64'h55);

        // Same-cycle reserve and commit of 5: reserve wins (ptr=2, search 2,0,1).
        rsv_valid = 1'b1;
        rsv_addr  = 5'd5;
        #1 chk("same_ready", 64'(req_ready), 64'b010);
        @(negedge clk);
        chk("same_busy", 64'(busy), 64'h20);
        chk("same_we", 64'(RegWrite), 64'd1);

        // Reserve 9 while committing 5: both apply.
        rsv_addr = 5'd9;
        @(negedge clk);
        rsv_valid = 1'b0;
        busy_exp  = 64'h200;
        chk("diff_busy", 64'(busy), busy_exp);
        chk("diff_a3", 64'(A3), 64'd5);

        // Commit to a register that is not busy still writes.
        set_req(5'd1, 5'd12, 5'd3, D0, 32'h0000_0C0C, D2);
        @(negedge clk);
        chk("nobusy_we", 64'(RegWrite), 64'd1);
        chk("nobusy_a3", 64'(A3), 64'd12);
        chk("nobusy_busy", 64'(busy), busy_exp);

        // Requester 0 writes register 0: handshake, no write, A3/WD3 hold.
        set_req(5'd0, 5'd2, 5'd3, 32'h1234_5678, D1, D2);
        req_valid = 3'b001;
        #1 chk("a0_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        chk("a0_we", 64'(RegWrite), 64'd0);
        chk("a0_a3_hold", 64'(A3), 64'd12);
        chk("a0_wd3_hold", 64'(WD3), 64'h0C0C);
        chk("a0_busy", 64'(busy), busy_exp);

        // Stall for 3 cycles with all valid; pointer (now 1) must survive.
        set_req(5'd1, 5'd2, 5'd3, D0, D1, D2);
        stall     = 1'b1;
        req_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("stall_ready_%0d", k), 64'(req_ready), 64'd0);
            @(negedge clk);
            chk($sformatf("stall_we_%0d", k), 64'(RegWrite), 64'd0);
        end
        stall = 1'b0;
        #1 chk("unstall_ready", 64'(req_ready), 64'b010);
        @(negedge clk);
        chk("unstall_we", 64'(RegWrite), 64'd1);
        chk("unstall_a3", 64'(A3), 64'd2);
        chk("unstall_wd3", 64'(WD3), 64'(D1));

        // Mid-stream reset with RegWrite and busy set.
        rsv_valid = 1'b1;
        rsv_addr  = 5'd20;
        #1 chk("pre_rst_ready", 64'(req_ready), 64'b100);
        @(negedge clk);
        rsv_valid = 1'b0;
        chk("pre_rst_we", 64'(RegWrite), 64'd1);
        chk("pre_rst_a3", 64'(A3), 64'd3);
        chk("pre_rst_busy", 64'(busy), 64'h0010_0200);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_we", 64'(RegWrite), 64'd0);
        chk("mid_rst_a3", 64'(A3), 64'd0);
        chk("mid_rst_wd3", 64'(WD3), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("held_rst_we", 64'(RegWrite), 64'd0);
        rst = 1'b1;
        #1 chk("post_rst_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        chk("post_rst_we", 64'(RegWrite), 64'd1);
        chk("post_rst_a3", 64'(A3), 64'd1);
        chk("post_rst_wd3", 64'(WD3), 64'(D0));
        req_valid = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
